tnoc_flit_vc_buffer: RTL and testbench
======================================

Name: tnoc_flit_vc_buffer

Overview:
Per-virtual-channel input buffer that sits directly upstream of the flit arbiter stage. It accepts flits from a router input or a local port on a shared flit bus, with valid/ready per VC. Each VC has its own FIFO, and the block presents per-VC head-of-queue flits to the arbiter. It also reports, per VC, whether a new packet may be started (vc_available), so upstream senders never interleave packets within a VC.

Parameters:
FLIT_WIDTH, 64, total flit width in bits, including the type field.
CHANNELS, 2, number of virtual channels.
DEPTH, 4, FIFO entries per VC; must be a power of two, minimum 2.
HEAD_BIT, 0, bit index of the head marker within a flit.
TAIL_BIT, 1, bit index of the tail marker within a flit; a single-flit packet has both the head and tail markers set.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  CHANNELS  per-VC write request; at most one bit set per cycle
o_ready  out  CHANNELS  per-VC write acceptance
i_flit  in  FLIT_WIDTH  shared write flit
o_vc_available  out  CHANNELS  VC c may accept a new head flit
o_valid  out  CHANNELS  per-VC head-of-queue valid
i_ready  in  CHANNELS  per-VC read acceptance from the arbiter/mux
o_flit  out  CHANNELS*FLIT_WIDTH  per-VC head-of-queue flit; VC c occupies bits [c*FLIT_WIDTH +: FLIT_WIDTH]
o_acknowledgement  out  CHANNELS  o_valid & i_ready per VC

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- On reset:
  - all FIFOs are emptied (read pointer, write pointer and count = 0);
  - o_valid = 0, o_ready = all 1, o_vc_available = all 1, o_acknowledgement = 0;
  - o_flit = 0 and the packet state is IDLE;
  - a reset asserted mid-packet discards all stored flits and partial packets.
- Per-VC FIFO:
  - count width is log2(DEPTH)+1; pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH;
  - o_ready[c] = (count[c] != DEPTH), registered-state based only;
  - there is no write-through when full, even if a read occurs in the same cycle;
  - write occurs when i_valid[c] && o_ready[c];
  - read occurs when o_valid[c] && i_ready[c];
  - simultaneous read and write leaves count unchanged and advances both pointers.
- Output timing:
  - o_valid[c] = (count[c] != 0); o_flit slice c = storage[c][read pointer];
  - latency from write to visibility on the output is 1 cycle; there is no bypass path;
  - o_flit is stable while o_valid is high and i_ready is low;
  - o_acknowledgement = o_valid & i_ready, combinational.
- Write-side packet state machine, per VC: IDLE and IN_PACKET.
  - IDLE, on accepted flit with head=1, tail=0: go to IN_PACKET.
  - IDLE, on accepted flit with head=1, tail=1: stay in IDLE.
  - IN_PACKET, on accepted flit with tail=1: go to IDLE.
  - IN_PACKET, on accepted flit with head=1: protocol violation; the flit is still stored, the state is unchanged, and an assertion fires in simulation.
  - IDLE, on accepted flit with head=0: protocol violation; the flit is stored, the state stays IDLE, and an assertion fires.
- o_vc_available[c] is registered and equals next-state(IDLE) && (free entries after this cycle >= 1).
  - It drops the cycle after a multi-flit head is accepted.
  - It rises the cycle after the tail is accepted, provided space remains.
- Simultaneous events:
  - i_valid with more than one bit set is illegal and asserted against; behaviour is undefined.
  - Writes and reads on different VCs in the same cycle are independent.
- Full VC: o_ready[c] = 0 holds the sender off. The other VCs remain writable, so there is no head-of-line blocking across VCs.

Test Plan:
- Reset, then a single-flit packet (head=1, tail=1) on VC0 -> o_valid[0]=1 one cycle later with o_flit[63:0] equal to the input; o_vc_available[0] stays 1 throughout.
- 4-flit packet on VC1 with DEPTH=4 and i_ready[1]=0 -> o_ready[1] goes low after the 4th write; count=4; o_vc_available[1]=0; releasing i_ready drains the 4 flits in order on 4 consecutive cycles.
- Simultaneous read and write on a full VC0 -> write refused (o_ready[0]=0 that cycle); count becomes 3 and o_ready[0] returns to 1 the next cycle.
- Interleaved traffic: VC0 full and stalled, VC1 streams 8 flits -> all 8 VC1 flits are delivered with VC0 contents untouched; pointer wrap is verified on VC1.
- Mid-packet reset: 2 of 3 flits written on VC0, rst_n pulsed low asynchronously between clock edges -> o_valid=0 and o_vc_available=all 1 immediately; the next head is accepted in IDLE.
- Protocol violation: head flit sent while in IN_PACKET -> assertion fires, flit is stored, and o_vc_available stays 0 until a tail is accepted.

Source files
------------

// File: rtl/tnoc_flit_vc_buffer_if.sv
// tnoc_flit_vc_buffer_if
//   Bundle of the shared write bus and the per-VC head-of-queue read bus
//   of the virtual-channel input buffer.
//   Write side : i_valid/o_ready per VC, shared i_flit, o_vc_available per VC.
//   Read side  : o_valid/i_ready per VC, o_flit (VC c at [c*FLIT_WIDTH +: FLIT_WIDTH]),
//                o_acknowledgement = o_valid & i_ready.
//   modport slave  : the buffer itself.
//   modport master : the sender/arbiter environment around the buffer.
interface tnoc_flit_vc_buffer_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS-1:0]            i_valid;
  logic [CHANNELS-1:0]            o_ready;
  logic [FLIT_WIDTH-1:0]          i_flit;
  logic [CHANNELS-1:0]            o_vc_available;
  logic [CHANNELS-1:0]            o_valid;
  logic [CHANNELS-1:0]            i_ready;
  logic [CHANNELS*FLIT_WIDTH-1:0] o_flit;
  logic [CHANNELS-1:0]            o_acknowledgement;

  modport slave (
    input  i_valid, i_flit, i_ready,
    output o_ready, o_vc_available, o_valid, o_flit, o_acknowledgement
  );

  modport master (
    output i_valid, i_flit, i_ready,
    input  o_ready, o_vc_available, o_valid, o_flit, o_acknowledgement
  );
endinterface

// File: rtl/tnoc_flit_vc_buffer.sv
// tnoc_flit_vc_buffer
//   Per-virtual-channel input FIFO placed upstream of the flit arbiter.
//   Each VC owns a DEPTH-entry FIFO written from a shared flit bus and
//   presents its head-of-queue flit to the arbiter. A per-VC packet tracker
//   reports o_vc_available so senders never interleave packets within a VC.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : tnoc_flit_vc_buffer_if.slave (write bus + per-VC read bus)
//   CHECK_PROTOCOL enables the simulation-only packet framing assertions.
module tnoc_flit_vc_buffer #(
  parameter int FLIT_WIDTH     = 64,
  parameter int CHANNELS       = 2,
  parameter int DEPTH          = 4,
  parameter int HEAD_BIT       = 0,
  parameter int TAIL_BIT       = 1,
  parameter bit CHECK_PROTOCOL = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  tnoc_flit_vc_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE,
    IN_PACKET
  } packet_state_e;

  logic                           is_head;
  logic                           is_tail;
  logic [CHANNELS-1:0]            ready_vec;
  logic [CHANNELS-1:0]            valid_vec;
  logic [CHANNELS-1:0]            avail_vec;
  logic [CHANNELS*FLIT_WIDTH-1:0] flit_vec;

  assign is_head = bus.i_flit[HEAD_BIT];
  assign is_tail = bus.i_flit[TAIL_BIT];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    packet_state_e         state;
    packet_state_e         state_next;
    logic                  avail_q;
    logic                  wr_en;
    logic                  rd_en;

    // Acceptance looks only at the registered count, so a full FIFO refuses
    // a write even when the arbiter drains it in the same cycle.
    assign wr_en = bus.i_valid[c] && (count != FULL_COUNT);
    assign rd_en = (count != '0) && bus.i_ready[c];

    always_comb begin
      count_next = count;
      if (wr_en && !rd_en) begin
        count_next = count + 1'b1;
      end else if (!wr_en && rd_en) begin
        count_next = count - 1'b1;
      end
    end

    // Framing errors (head inside a packet, body/tail while idle) still
    // store the flit but never change the packet state.
    always_comb begin
      state_next = state;
      if (wr_en) begin
        if (state == IDLE) begin
          if (is_head && !is_tail) begin
            state_next = IN_PACKET;
          end
        end else if (is_tail && !is_head) begin
          state_next = IDLE;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        state   <= IDLE;
        avail_q <= 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= bus.i_flit;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count   <= count_next;
        state   <= state_next;
        // A new packet may start only once idle with at least one free slot.
        avail_q <= (state_next == IDLE) && (count_next != FULL_COUNT);
      end
    end

    assign ready_vec[c]                          = (count != FULL_COUNT);
    assign valid_vec[c]                          = (count != '0);
    assign avail_vec[c]                          = avail_q;
    assign flit_vec[c*FLIT_WIDTH +: FLIT_WIDTH]  = mem[rd_ptr];

    if (CHECK_PROTOCOL) begin : g_check
      always @(posedge clk) begin
        if (rst_n && wr_en) begin
          a_head_in_packet: assert (!((state == IN_PACKET) && is_head));
          a_body_while_idle: assert (!((state == IDLE) && !is_head));
        end
      end
    end
  end

  assign bus.o_ready           = ready_vec;
  assign bus.o_valid           = valid_vec;
  assign bus.o_vc_available    = avail_vec;
  assign bus.o_flit            = flit_vec;
  assign bus.o_acknowledgement = valid_vec & bus.i_ready;

  always @(posedge clk) begin
    if (rst_n) begin
      a_onehot_write: assert ($onehot0(bus.i_valid));
    end
  end
endmodule

// File: tb/tb_tnoc_flit_vc_buffer.sv
// tb_tnoc_flit_vc_buffer
//   Self-checking bench for tnoc_flit_vc_buffer (FLIT_WIDTH=64, CHANNELS=2,
//   DEPTH=4). A queue-based model of each VC is compared against the DUT on
//   every falling clock edge; directed scenarios add literal expectations.
module tb_tnoc_flit_vc_buffer;
  localparam int FW    = 64;
  localparam int CH    = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  int n_compared = 0;
  int n_mismatch = 0;

  tnoc_flit_vc_buffer_if #(.FLIT_WIDTH(FW), .CHANNELS(CH)) bus ();

  tnoc_flit_vc_buffer #(
    .FLIT_WIDTH    (FW),
    .CHANNELS      (CH),
    .DEPTH         (DEPTH),
    .HEAD_BIT      (0),
    .TAIL_BIT      (1),
    .CHECK_PROTOCOL(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one queue per VC, a packet-open flag and the
  // availability that follows from them after each clock edge.
  logic [FW-1:0] mq [CH][$];
  logic [CH-1:0] m_in_pkt;
  logic [CH-1:0] m_avail;

  initial begin
    m_in_pkt = '0;
    m_avail  = '1;
  end

  always @(negedge rst_n) begin
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_in_pkt = '0;
    m_avail  = '1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        bit do_rd;
        bit do_wr;
        bit h;
        bit t;
        do_rd = (mq[c].size() != 0) && bus.i_ready[c];
        do_wr = bus.i_valid[c] && (mq[c].size() < DEPTH);
        h = bus.i_flit[0];
        t = bus.i_flit[1];
        if (do_rd) void'(mq[c].pop_front());
        if (do_wr) begin
          mq[c].push_back(bus.i_flit);
          if (!m_in_pkt[c]) begin
            if (h && !t) m_in_pkt[c] = 1'b1;
          end else if (t && !h) begin
            m_in_pkt[c] = 1'b0;
          end
        end
        m_avail[c] = !m_in_pkt[c] && (mq[c].size() < DEPTH);
      end
    end
  end

  task automatic checkValue(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [CH-1:0] ev;
    logic [CH-1:0] er;
    logic [CH-1:0] ea;
    for (int c = 0; c < CH; c++) begin
      ev[c] = (mq[c].size() != 0);
      er[c] = (mq[c].size() < DEPTH);
      ea[c] = ev[c] & bus.i_ready[c];
    end
    checkValue("model o_valid", FW'(bus.o_valid), FW'(ev));
    checkValue("model o_ready", FW'(bus.o_ready), FW'(er));
    checkValue("model o_acknowledgement", FW'(bus.o_acknowledgement), FW'(ea));
    checkValue("model o_vc_available", FW'(bus.o_vc_available), FW'(m_avail));
    for (int c = 0; c < CH; c++) begin
      if (ev[c]) checkValue($sformatf("model o_flit[%0d]", c), bus.o_flit[c*FW +: FW], mq[c][0]);
    end
  endtask

  always @(negedge clk) checkOutput();

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic applyStimulus(input logic [CH-1:0] v, input logic [FW-1:0] f, input logic [CH-1:0] r);
    @(posedge clk);
    #1;
    bus.i_valid = v;
    bus.i_flit  = f;
    bus.i_ready = r;
  endtask

  task automatic idle();
    applyStimulus('0, '0, '0);
  endtask

  function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [61:0] payload);
    return {payload, t, h};
  endfunction

  logic [FW-1:0] s [8];
  logic [FW-1:0] f1;
  logic [FW-1:0] p [4];
  logic [FW-1:0] v0 [5];
  logic [FW-1:0] h3;
  logic [FW-1:0] h4;
  logic [FW-1:0] h5;
  logic [FW-1:0] t4;
  int got;
  int cyc;

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = '0;
    bus.i_flit  = '0;
    bus.i_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset o_valid", FW'(bus.o_valid), 64'h0);
    checkValue("reset o_ready", FW'(bus.o_ready), 64'h3);
    checkValue("reset o_vc_available", FW'(bus.o_vc_available), 64'h3);
    checkValue("reset o_flit vc1", bus.o_flit[127:64], 64'h0);
    #2 rst_n = 1'b1;

    // Single-flit packet on VC0.
    $display("[TB] single-flit packet on VC0");
    f1 = mk(1'b1, 1'b1, 62'h0123_4567_89AB_CDE);
    applyStimulus(2'b01, f1, 2'b00);
    idle();
    @(negedge clk);
    checkValue("single o_valid[0]", FW'(bus.o_valid[0]), 64'h1);
    checkValue("single o_flit[0]", bus.o_flit[63:0], f1);
    checkValue("single o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h1);
    applyStimulus(2'b00, '0, 2'b01);
    idle();

    // Four-flit packet on stalled VC1 fills it, then drains in order.
    $display("[TB] four-flit packet on VC1");
    p[0] = mk(1'b1, 1'b0, 62'hA0);
    p[1] = mk(1'b0, 1'b0, 62'hA1);
    p[2] = mk(1'b0, 1'b0, 62'hA2);
    p[3] = mk(1'b0, 1'b1, 62'hA3);
    for (int k = 0; k < 4; k++) applyStimulus(2'b10, p[k], 2'b00);
    idle();
    @(negedge clk);
    checkValue("vc1 full o_ready[1]", FW'(bus.o_ready[1]), 64'h0);
    checkValue("vc1 full o_vc_available[1]", FW'(bus.o_vc_available[1]), 64'h0);
    checkValue("vc1 full o_flit[1]", bus.o_flit[127:64], p[0]);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, '0, 2'b10);
      @(negedge clk);
      checkValue($sformatf("vc1 drain flit %0d", k), bus.o_flit[127:64], p[k]);
      checkValue($sformatf("vc1 drain ack %0d", k), FW'(bus.o_acknowledgement[1]), 64'h1);
    end
    idle();
    @(negedge clk);
    checkValue("vc1 drained o_vc_available[1]", FW'(bus.o_vc_available[1]), 64'h1);

    // Full VC0: simultaneous read and write must refuse the write.
    $display("[TB] read and write on full VC0");
    for (int k = 0; k < 5; k++) v0[k] = mk(1'b1, 1'b1, 62'hB0 + 62'(k));
    for (int k = 0; k < 4; k++) applyStimulus(2'b01, v0[k], 2'b00);
    applyStimulus(2'b01, mk(1'b1, 1'b1, 62'hDEAD), 2'b01);
    @(negedge clk);
    checkValue("full rw o_ready[0]", FW'(bus.o_ready[0]), 64'h0);
    idle();
    @(negedge clk);
    checkValue("after rw o_ready[0]", FW'(bus.o_ready[0]), 64'h1);
    checkValue("after rw o_flit[0]", bus.o_flit[63:0], v0[1]);
    applyStimulus(2'b01, v0[4], 2'b00);

    // VC0 full and stalled while VC1 streams 8 flits through wrapping pointers.
    $display("[TB] VC1 stream with VC0 stalled");
    for (int k = 0; k < 8; k++) s[k] = mk(k % 4 == 0, k % 4 == 3, 62'hC0 + 62'(k));
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 14) begin
      if (cyc < 8) applyStimulus(2'b10, s[cyc], 2'b10);
      else applyStimulus(2'b00, '0, 2'b10);
      @(negedge clk);
      if (bus.o_acknowledgement[1]) begin
        checkValue($sformatf("stream flit %0d", got), bus.o_flit[127:64], s[got]);
        got++;
      end
      cyc++;
    end
    checkValue("stream delivered count", FW'(got), 64'd8);
    checkValue("stalled o_ready[0]", FW'(bus.o_ready[0]), 64'h0);
    checkValue("stalled o_flit[0]", bus.o_flit[63:0], v0[1]);
    idle();
    repeat (4) applyStimulus(2'b00, '0, 2'b01);
    idle();

    // Mid-packet asynchronous reset.
    $display("[TB] mid-packet reset on VC0");
    applyStimulus(2'b01, mk(1'b1, 1'b0, 62'hD0), 2'b00);
    applyStimulus(2'b01, mk(1'b0, 1'b0, 62'hD1), 2'b00);
    idle();
    #1 rst_n = 1'b0;
    #1;
    checkValue("async reset o_valid", FW'(bus.o_valid), 64'h0);
    checkValue("async reset o_vc_available", FW'(bus.o_vc_available), 64'h3);
    checkValue("async reset o_ready", FW'(bus.o_ready), 64'h3);
    @(negedge clk);
    #2 rst_n = 1'b1;
    h3 = mk(1'b1, 1'b0, 62'hE0);
    applyStimulus(2'b01, h3, 2'b00);
    idle();
    @(negedge clk);
    checkValue("post reset head o_flit[0]", bus.o_flit[63:0], h3);
    checkValue("post reset head o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h0);
    applyStimulus(2'b01, mk(1'b0, 1'b1, 62'hE1), 2'b00);
    idle();
    @(negedge clk);
    checkValue("post reset tail o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h1);
    repeat (2) applyStimulus(2'b00, '0, 2'b01);
    idle();

    // Head flit inside an open packet is stored; VC stays unavailable until a tail.
    $display("[TB] head inside open packet on VC0");
    h4 = mk(1'b1, 1'b0, 62'hF0);
    h5 = mk(1'b1, 1'b0, 62'hF1);
    t4 = mk(1'b0, 1'b1, 62'hF2);
    applyStimulus(2'b01, h4, 2'b00);
    applyStimulus(2'b01, h5, 2'b00);
    idle();
    @(negedge clk);
    checkValue("violation o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h0);
    applyStimulus(2'b00, '0, 2'b01);
    idle();
    @(negedge clk);
    checkValue("violation stored o_flit[0]", bus.o_flit[63:0], h5);
    applyStimulus(2'b00, '0, 2'b01);
    idle();
    @(negedge clk);
    checkValue("violation empty o_valid[0]", FW'(bus.o_valid[0]), 64'h0);
    checkValue("violation empty o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h0);
    applyStimulus(2'b01, t4, 2'b00);
    idle();
    @(negedge clk);
    checkValue("violation tail o_vc_available[0]", FW'(bus.o_vc_available[0]), 64'h1);
    checkValue("violation tail o_flit[0]", bus.o_flit[63:0], t4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end
endmodule
